// File: rtl/qrr_pkg.sv
// -----------------------------------------------------------------------------
// qrr_pkg
// Shared definitions for the packet-level round-robin arbiter.
//   state_e     : arbiter FSM encoding (IDLE / LOCKED).
//   idx_width   : width of the granted-index prefix, never below 1.
//   word_width  : input word width  = {eot[LVL-1:0], data[TDIN-1:0]}.
//   out_width   : output word width = {idx[IDW-1:0], eot[LVL-1:0], data[TDIN-1:0]}.
//   last_pos    : bit position of the outermost eot bit inside an input word.
// -----------------------------------------------------------------------------
package qrr_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    function automatic int idx_width(input int num);
        return (num > 2) ? $clog2(num) : 1;
    endfunction

    function automatic int word_width(input int tdin, input int lvl);
        return tdin + lvl;
    endfunction

    function automatic int out_width(input int num, input int tdin, input int lvl);
        return idx_width(num) + tdin + lvl;
    endfunction

    // With LVL==0 this points at the payload MSB; callers ignore it in that case.
    function automatic int last_pos(input int tdin, input int lvl);
        return tdin + lvl - 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Finds the first asserted request scanning
// ptr+1, ptr+2, ... modulo NUM.
//   req_i     [NUM-1:0] : request vector.
//   ptr_i     [IDW-1:0] : last-granted index.
//   gnt_idx_o [IDW-1:0] : chosen index (0 when nothing requests).
//   any_req_o           : at least one request is asserted.
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM = 2,
    parameter int IDW = 1
) (
    input  logic [NUM-1:0] req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [IDW-1:0] gnt_idx_o,
    output logic           any_req_o
);

    logic [2*NUM-1:0] req_dbl;
    logic [NUM-1:0]   req_rot;
    logic [IDW:0]     start;

    // start may equal NUM (ptr = NUM-1); shifting the doubled vector by NUM
    // yields req_i itself, so the wrap needs no special case.
    assign start   = {1'b0, ptr_i} + (IDW+1)'(1);
    assign req_dbl = {req_i, req_i};
    assign req_rot = NUM'(req_dbl >> start);

    // Lowest set bit of the rotated vector, mapped back to an absolute index.
    always_comb begin
        logic found;
        int   pos;
        found     = 1'b0;
        pos       = 0;
        gnt_idx_o = '0;
        for (int j = 0; j < NUM; j++) begin
            if (!found && req_rot[j]) begin
                found = 1'b1;
                pos   = int'(start) + j;
                if (pos >= NUM) begin
                    pos = pos - NUM;
                end
                gnt_idx_o = IDW'(pos);
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/qrr_arbiter.sv
// -----------------------------------------------------------------------------
// qrr_arbiter
// Packet-level round-robin arbiter: NUM eot-delimited input streams share one
// output stream. A grant stays on one input from its first transfer until the
// transfer carrying its outermost eot bit, so packets never interleave. The
// output word is prefixed with the granted input index.
//
// Handshake (both sides): a word moves on a cycle where dvalid & dready are
// both high. A producer holding dvalid keeps data stable until accepted;
// dvalid never depends combinationally on dready.
//
// Ports:
//   clk_i                         : clock.
//   rst_ni                        : asynchronous active-low reset.
//   din_dvalid_i [NUM-1:0]        : per-input valid.
//   din_data_i   [NUM*DW-1:0]     : input i word at [i*DW +: DW], {eot, data}.
//   din_dready_o [NUM-1:0]        : per-input ready (only the selected one).
//   dout_dvalid_o                 : output valid.
//   dout_data_o  [OW-1:0]         : {idx, eot, data}.
//   dout_dready_i                 : output ready.
//   state_o                       : FSM state (0 = IDLE, 1 = LOCKED).
// -----------------------------------------------------------------------------
module qrr_arbiter
    import qrr_pkg::*;
#(
    parameter  int NUM  = 2,
    parameter  int TDIN = 16,
    parameter  int LVL  = 1,
    localparam int IDW  = idx_width(NUM),
    localparam int DW   = word_width(TDIN, LVL),
    localparam int OW   = out_width(NUM, TDIN, LVL)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM-1:0]    din_dvalid_i,
    input  logic [NUM*DW-1:0] din_data_i,
    output logic [NUM-1:0]    din_dready_o,
    output logic              dout_dvalid_o,
    output logic [OW-1:0]     dout_data_o,
    input  logic              dout_dready_i,
    output logic              state_o
);

    state_e         state_q, state_d;
    logic [IDW-1:0] lock_idx_q, lock_idx_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    logic [IDW-1:0] pick_idx;
    logic           any_req;
    logic [IDW-1:0] sel;
    logic [DW-1:0]  sel_word;
    logic           sel_valid;
    logic           last;
    logic           xfer;

    rr_pick #(
        .NUM (NUM),
        .IDW (IDW)
    ) u_pick (
        .req_i     (din_dvalid_i),
        .ptr_i     (rr_ptr_q),
        .gnt_idx_o (pick_idx),
        .any_req_o (any_req)
    );

    assign sel = (state_q == ST_LOCKED) ? lock_idx_q : pick_idx;

    // Word mux. In IDLE the picked input is valid exactly when any input is.
    always_comb begin
        logic locked_valid;
        sel_word     = '0;
        locked_valid = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            if (IDW'(i) == sel) begin
                sel_word     = din_data_i[i*DW +: DW];
                locked_valid = din_dvalid_i[i];
            end
        end
        sel_valid = (state_q == ST_LOCKED) ? locked_valid : any_req;
    end

    assign last = (LVL == 0) ? 1'b1 : sel_word[last_pos(TDIN, LVL)];
    assign xfer = dout_dvalid_o & dout_dready_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            lock_idx_q <= '0;
            rr_ptr_q   <= IDW'(NUM - 1);
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Next-state logic. A presented but stalled word in IDLE also locks, so a
    // newly rising input cannot steal the selection from a held word.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (dout_dvalid_o) begin
                    if (xfer && last) begin
                        rr_ptr_d = sel;
                    end else begin
                        state_d    = ST_LOCKED;
                        lock_idx_d = sel;
                    end
                end
            end
            ST_LOCKED: begin
                if (xfer && last) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = lock_idx_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic, gated off while reset is asserted.
    always_comb begin
        dout_dvalid_o = 1'b0;
        din_dready_o  = '0;
        if (rst_ni) begin
            dout_dvalid_o = sel_valid;
            for (int i = 0; i < NUM; i++) begin
                if (IDW'(i) == sel) begin
                    din_dready_o[i] = dout_dready_i;
                end
            end
        end
    end

    assign dout_data_o = {sel, sel_word};
    assign state_o     = state_q;

endmodule

// File: tb/tb_qrr_arbiter.sv
module tb_qrr_arbiter;

    // DUT 0: NUM=4, TDIN=16, LVL=1 -> word 17 bits, output 19 bits.
    // DUT 1: NUM=3, TDIN=8,  LVL=0 -> word 8 bits,  output 10 bits.
    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  v0;
    logic [67:0] d0;
    logic [3:0]  r0;
    logic        ov0;
    logic [18:0] od0;
    logic        rdy0;
    logic        st0;

    logic [2:0]  v1;
    logic [23:0] d1;
    logic [2:0]  r1;
    logic        ov1;
    logic [9:0]  od1;
    logic        rdy1;
    logic        st1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    qrr_arbiter #(.NUM(4), .TDIN(16), .LVL(1)) u_dut0 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .din_dvalid_i  (v0),
        .din_data_i    (d0),
        .din_dready_o  (r0),
        .dout_dvalid_o (ov0),
        .dout_data_o   (od0),
        .dout_dready_i (rdy0),
        .state_o       (st0)
    );

    qrr_arbiter #(.NUM(3), .TDIN(8), .LVL(0)) u_dut1 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .din_dvalid_i  (v1),
        .din_data_i    (d1),
        .din_dready_o  (r1),
        .dout_dvalid_o (ov1),
        .dout_data_o   (od1),
        .dout_dready_i (rdy1),
        .state_o       (st1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set0(input int i, input logic eot, input logic [15:0] pl);
        d0[i*17 +: 17] = {eot, pl};
    endtask

    // Expected DUT 0 output word: {idx, eot, payload}.
    function automatic logic [31:0] e0(input logic [1:0] idx, input logic eot, input logic [15:0] pl);
        return {13'd0, idx, eot, pl};
    endfunction

    // Expected DUT 1 output word: {idx, payload}.
    function automatic logic [31:0] e1(input logic [1:0] idx, input logic [7:0] pl);
        return {22'd0, idx, pl};
    endfunction

    initial begin
        rst_n = 1'b0;
        v0 = '0; d0 = '0; rdy0 = 1'b0;
        v1 = '0; d1 = '0; rdy1 = 1'b0;

        // Reset: outputs gated even with inputs valid and ready high.
        @(negedge clk);
        v0 = 4'hF; rdy0 = 1'b1;
        #1;
        chk("rst_dvalid", 32'(ov0), 32'd0);
        chk("rst_ready",  32'(r0),  32'd0);
        chk("rst_state",  32'(st0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; v0 = '0; rdy0 = 1'b0;

        // Fairness: all four inputs send single-word packets.
        for (int i = 0; i < 4; i++) set0(i, 1'b1, 16'(16'hA000 + i));
        v0 = 4'hF; rdy0 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("fair_valid", 32'(ov0), 32'd1);
            chk("fair_data",  32'(od0), e0(2'(k % 4), 1'b1, 16'(16'hA000 + (k % 4))));
            chk("fair_ready", 32'(r0),  32'(1 << (k % 4)));
            @(negedge clk);
        end

        // Packet lock: single word from input 1 moves the pointer to 1,
        // then input 2 holds a 3-word packet while input 0 waits.
        v0 = 4'b0010; set0(1, 1'b1, 16'h1001);
        #1;
        chk("lock_pre", 32'(od0), e0(2'd1, 1'b1, 16'h1001));
        @(negedge clk);
        v0 = 4'b0101; set0(0, 1'b1, 16'h0A0A);
        for (int w = 0; w < 3; w++) begin
            set0(2, (w == 2), 16'(16'h2001 + w));
            #1;
            chk("lock_data",  32'(od0), e0(2'd2, (w == 2), 16'(16'h2001 + w)));
            chk("lock_ready", 32'(r0),  32'h4);
            chk("lock_state", 32'(st0), 32'(w > 0));
            @(negedge clk);
        end
        v0 = 4'b0001;
        #1;
        chk("lock_after",       32'(od0), e0(2'd0, 1'b1, 16'h0A0A));
        chk("lock_after_state", 32'(st0), 32'd0);
        @(negedge clk);

        // Backpressure hold: input 1 stalled 5 cycles, input 0 rises mid-stall.
        v0 = 4'b0010; set0(1, 1'b1, 16'h1111); rdy0 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                v0 = 4'b0011; set0(0, 1'b1, 16'h0B0B);
            end
            #1;
            chk("bp_valid", 32'(ov0), 32'd1);
            chk("bp_data",  32'(od0), e0(2'd1, 1'b1, 16'h1111));
            chk("bp_ready", 32'(r0),  32'd0);
            @(negedge clk);
        end
        rdy0 = 1'b1;
        #1;
        chk("bp_accept",       32'(od0), e0(2'd1, 1'b1, 16'h1111));
        chk("bp_accept_ready", 32'(r0),  32'h2);
        @(negedge clk);
        v0 = 4'b0001;
        #1;
        chk("bp_next", 32'(od0), e0(2'd0, 1'b1, 16'h0B0B));
        @(negedge clk);

        // Lock with source gap: pointer to 2, then input 3 packet with a gap.
        v0 = 4'b0100; set0(2, 1'b1, 16'h2222);
        #1;
        chk("gap_pre", 32'(od0), e0(2'd2, 1'b1, 16'h2222));
        @(negedge clk);
        v0 = 4'b1010; set0(3, 1'b0, 16'h3001); set0(1, 1'b1, 16'h1234);
        #1;
        chk("gap_first", 32'(od0), e0(2'd3, 1'b0, 16'h3001));
        @(negedge clk);
        v0 = 4'b0010;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk("gap_valid", 32'(ov0), 32'd0);
            chk("gap_block", 32'(r0),  32'h8);
            @(negedge clk);
        end
        v0 = 4'b1010; set0(3, 1'b1, 16'h3002);
        #1;
        chk("gap_last", 32'(od0), e0(2'd3, 1'b1, 16'h3002));
        @(negedge clk);
        v0 = 4'b0010;
        #1;
        chk("gap_resume",       32'(od0), e0(2'd1, 1'b1, 16'h1234));
        chk("gap_resume_valid", 32'(ov0), 32'd1);
        @(negedge clk);

        // Reset mid-packet on input 1.
        v0 = 4'b0010; set0(1, 1'b0, 16'h1AAA);
        #1;
        chk("rstm_first", 32'(od0), e0(2'd1, 1'b0, 16'h1AAA));
        @(negedge clk);
        rst_n = 1'b0; v0 = 4'b0011; set0(1, 1'b1, 16'h1BBB); set0(0, 1'b1, 16'h0C0C);
        #1;
        chk("rstm_valid", 32'(ov0), 32'd0);
        chk("rstm_ready", 32'(r0),  32'd0);
        chk("rstm_state", 32'(st0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstm_grant",       32'(od0), e0(2'd0, 1'b1, 16'h0C0C));
        chk("rstm_grant_valid", 32'(ov0), 32'd1);
        @(negedge clk);
        v0 = '0; rdy0 = 1'b0;

        // LVL=0, NUM=3: inputs 0 and 2 alternate every word.
        d1 = {8'h12, 8'h11, 8'h10};
        v1 = 3'b101; rdy1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("lvl0_data",  32'(od1), e1((k % 2 == 0) ? 2'd0 : 2'd2, (k % 2 == 0) ? 8'h10 : 8'h12));
            chk("lvl0_state", 32'(st1), 32'd0);
            @(negedge clk);
        end
        // Stall on LVL=0 holds the word and locks until accepted.
        rdy1 = 1'b0;
        #1;
        chk("lvl0_stall_data", 32'(od1), e1(2'd0, 8'h10));
        @(negedge clk);
        #1;
        chk("lvl0_stall_state", 32'(st1), 32'd1);
        chk("lvl0_stall_hold",  32'(od1), e1(2'd0, 8'h10));
        rdy1 = 1'b1;
        @(negedge clk);
        #1;
        chk("lvl0_after_stall", 32'(od1), e1(2'd2, 8'h12));
        chk("lvl0_after_state", 32'(st1), 32'd0);
        @(negedge clk);
        v1 = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/qrr_arbiter.md
Name: qrr_arbiter

Overview:
- Packet-level round-robin arbiter sharing one downstream eot-delimited datapath, e.g. a flatten stage, among NUM producer streams.
- Grant is locked to one input from its first transfer until the transfer that carries that input's outermost eot bit, so transactions never interleave.
- Output data is prefixed with the granted input index so downstream logic can route responses or tag packets.
- Sits between N DTI queue producers and a single DTI consumer.

Parameters:
- NUM, 2: number of input streams (2..16).
- TDIN, 16: payload width, excluding eot bits.
- LVL, 1: number of eot bits per input word (0..8); 0 means every word is a complete packet.
- IDW, $clog2(NUM): width of the index field; derived, minimum 1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: asynchronous, active-low.
- din[NUM]  dti_s_if.consumer  TDIN+LVL  input streams; data = {eot[LVL-1:0], data[TDIN-1:0]}.
- dout  dti_s_if.producer  IDW+TDIN+LVL  arbitrated stream; data = {idx[IDW-1:0], eot[LVL-1:0], data[TDIN-1:0]}.

Behaviour:
- Registers:
  - state ∈ {IDLE, LOCKED}.
  - lock_idx[IDW-1:0].
  - rr_ptr[IDW-1:0], the last-granted index.
- Reset (rst=0, asynchronous): state=IDLE, lock_idx=0, rr_ptr=NUM-1, so input 0 has first priority.
  - While rst=0: dout.dvalid=0 and all din.dready=0, gated combinationally.
- Selection is combinational, zero latency. sel is:
  - lock_idx in LOCKED.
  - in IDLE, the first i with din[i].dvalid=1 scanning rr_ptr+1, rr_ptr+2, … modulo NUM.
- Outputs:
  - dout.dvalid = din[sel].dvalid (0 in IDLE when no input is valid).
  - dout.data = {sel, din[sel].data}.
  - dout.eot = din[sel].eot.
  - din[sel].dready = dout.dready; all other din.dready=0.
- Handshake: xfer = dout.dvalid & dout.dready. No combinational path from dout.dready to dout.dvalid; dvalid of a held word must stay stable until accepted.
- last = (LVL==0) ? 1 : din[sel].data[TDIN+LVL-1], i.e. the outermost eot bit.
- Transitions:
  - IDLE, no valid input: stay in IDLE; rr_ptr unchanged.
  - IDLE, valid but no xfer (dout.dready=0): stay in IDLE. Selection may change if new inputs rise, but once dout.dvalid=1 the selection is held: sel is registered into lock_idx and state goes to LOCKED on the first cycle dout.dvalid=1 & !xfer. This keeps a presented word stable.
  - IDLE, xfer & last: stay in IDLE; rr_ptr=sel (single-word packet).
  - IDLE, xfer & !last: go to LOCKED; lock_idx=sel.
  - LOCKED, xfer & last: go to IDLE; rr_ptr=lock_idx.
  - LOCKED otherwise: stay in LOCKED. The locked input dropping dvalid mid-packet is legal: dout.dvalid=0, lock is kept, other inputs stay blocked.
- LVL==0: state never leaves IDLE except for the stall-hold case above; every word rotates priority.
- NUM not a power of 2: the scan wraps at NUM-1 → 0; indices ≥ NUM are never selected.
- Reset mid-packet drops the lock; the downstream stage must tolerate a truncated packet.
- Throughput: one word per cycle, including back-to-back packets from different inputs with no bubble.

Decomposition:
- Package qrr_pkg:
  - function idx_width(NUM), returning max(1, $clog2(NUM)).
  - parameterised struct helpers for the din and dout words: eot field, data field, idx prefix.
- Sub-module rr_pick (combinational):
  - inputs: req[NUM], ptr[IDW].
  - outputs: gnt_idx[IDW], any_req.
  - implemented as a double-width rotate plus priority encoder.
- The top module holds the FSM, the lock/pointer registers and the interface muxing.

Test Plan:
- Fairness: NUM=4, LVL=1, all inputs continuously send 1-word packets (eot=1), dout.dready=1 → dout.idx sequence 0,1,2,3,0,… with dvalid held high every cycle.
- Packet lock: input 2 sends 3 words (eot 0,0,1) while input 0 is valid throughout → idx=2 for 3 consecutive xfers, then idx=0; din[0].dready=0 during the lock.
- Backpressure hold: dout.dready=0 for 5 cycles while input 1 is presented and input 0 rises mid-stall → dout.data stays stable with idx=1 until accepted.
- Lock with source gap: input 3 sends word (eot=0), deasserts dvalid for 4 cycles, then sends eot=1; input 1 is valid throughout → dout.dvalid=0 during the gap, then idx=3, then idx=1.
- Reset mid-packet: rst=0 after the first word of a 2-word packet on input 1 → dout.dvalid=0 immediately; after release, input 0 is granted first when inputs 0 and 1 are both valid.
- LVL=0, NUM=3: inputs 0 and 2 valid → alternating idx 0,2,0,2; index 3 never appears.
